icache_fill_responder: RTL

Memory-side responder for instruction-cache line fills. Accepts one line-fill request at a time from the icache and issues 16 sequential word reads to a fixed-latency backing memory. It streams the returned words back to the cache in order, with an index and a last flag. It also services single-word data writes to the same memory and, for each write, emits a line-invalidate notice so the cache can drop any stale tag.

---
 rtl/icache_fill_responder_pkg.sv | 16 +
 rtl/icache_fill_responder_mem_rd_tracker.sv | 40 ++++
 rtl/icache_fill_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/icache_fill_responder_pkg.sv
// Shared types and line geometry for the instruction-cache fill responder.
package icache_pkg;

  localparam int unsigned LINE_WORDS  = 16;
  localparam int unsigned WORD_IDX_W  = 4;
  localparam int unsigned ADDR_W      = 24;
  localparam int unsigned LINE_ADDR_W = ADDR_W - WORD_IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE
  } fill_state_t;

endpackage

// File: rtl/icache_fill_responder_mem_rd_tracker.sv
// Delay line that pairs each issued read with its word index so the returning
// memory data can be tagged when it arrives MEM_LATENCY cycles later.
module mem_rd_tracker #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [IDX_W-1:0] issue_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  logic             r_valid [MEM_LATENCY];
  logic [IDX_W-1:0] r_idx   [MEM_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
        r_valid[i] <= 1'b0;
        r_idx[i]   <= '0;
      end
    end else begin
      r_valid[0] <= issue_valid;
      r_idx[0]   <= issue_valid ? issue_idx : '0;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_idx[i]   <= r_idx[i-1];
      end
    end
  end

  // Line size is a power of two, so the final word index is all ones.
  assign out_valid = r_valid[MEM_LATENCY-1];
  assign out_idx   = r_idx[MEM_LATENCY-1];
  assign out_last  = r_valid[MEM_LATENCY-1] && (r_idx[MEM_LATENCY-1] == '1);

endmodule

// File: rtl/icache_fill_responder.sv
// Services icache line fills as back-to-back word reads from a fixed-latency
// memory, and single-word data writes that also emit a line-invalidate notice.
module icache_fill_responder #(
  parameter  int unsigned LINE_WORDS  = 16,
  parameter  int unsigned MEM_LATENCY = 2,
  parameter  int unsigned ADDR_W      = 24,
  localparam int unsigned IDX_W       = $clog2(LINE_WORDS),
  localparam int unsigned LINE_W      = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_req,
  input  logic [LINE_W-1:0] fill_addr,
  output logic              fill_ack,
  output logic              fill_valid,
  output logic [31:0]       fill_data,
  output logic [IDX_W-1:0]  fill_idx,
  output logic              fill_last,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ack,
  output logic              inv_valid,
  output logic [LINE_W-1:0] inv_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  import icache_pkg::*;

  fill_state_t       r_state;
  logic [LINE_W-1:0] r_line;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_fill_ack;
  logic              r_wr_ack;
  logic              r_inv_valid;
  logic [LINE_W-1:0] r_inv_addr;
  logic              r_mem_re;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [IDX_W-1:0]  w_cnt_next;
  logic              w_trk_valid;
  logic [IDX_W-1:0]  w_trk_idx;
  logic              w_trk_last;
  logic              w_unused_bits;

  assign w_cnt_next    = r_cnt + 1'b1;
  assign w_unused_bits = ^wr_addr[1:0];

  // Outputs are registered so the word on mem_addr and r_cnt always agree,
  // which lets the tracker tag each read with r_cnt directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_line      <= '0;
      r_cnt       <= '0;
      r_fill_ack  <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_inv_valid <= 1'b0;
      r_inv_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_fill_ack  <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_inv_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wr_req) begin
            r_state     <= WRITE;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {wr_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= wr_data;
            r_wr_ack    <= 1'b1;
            r_inv_valid <= 1'b1;
            r_inv_addr  <= wr_addr[ADDR_W-1:IDX_W+2];
          end else if (fill_req) begin
            r_state    <= ISSUE;
            r_fill_ack <= 1'b1;
            r_line     <= fill_addr;
            r_cnt      <= '0;
            r_mem_re   <= 1'b1;
            r_mem_addr <= {fill_addr, {IDX_W{1'b0}}, 2'b00};
          end
        end
        ISSUE: begin
          if (r_cnt == '1) begin
            r_state    <= DRAIN;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
          end else begin
            r_cnt      <= w_cnt_next;
            r_mem_addr <= {r_line, w_cnt_next, 2'b00};
          end
        end
        DRAIN: begin
          if (w_trk_last) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        WRITE: begin
          r_state     <= IDLE;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_inv_addr  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_rd_tracker #(
    .MEM_LATENCY (MEM_LATENCY),
    .IDX_W       (IDX_W)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (r_mem_re),
    .issue_idx   (r_cnt),
    .out_valid   (w_trk_valid),
    .out_idx     (w_trk_idx),
    .out_last    (w_trk_last)
  );

  assign fill_ack   = r_fill_ack;
  assign fill_valid = w_trk_valid;
  assign fill_data  = w_trk_valid ? mem_rdata : '0;
  assign fill_idx   = w_trk_idx;
  assign fill_last  = w_trk_last;
  assign wr_ack     = r_wr_ack;
  assign inv_valid  = r_inv_valid;
  assign inv_addr   = r_inv_addr;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
